bus_interface_unit: RTL and testbench
=====================================

BUS_INTERFACE_UNIT -- requirements
Module: bus_interface_unit

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 1: clock cycles from address-stable to sampling mem_data_out; legal 1..7.
REQ-002 SHALL have parameter ADDR_W, default 16: address width.
REQ-003 SHALL have parameter DATA_W, default 32: data width.
REQ-004 SHALL have port clock, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_valid, input, 1: core request present.
REQ-007 SHALL have port req_ready, output, 1: unit can accept a request.
REQ-008 SHALL have port req_we, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, ADDR_W: word address.
REQ-010 SHALL have port req_wdata, input, DATA_W: write data.
REQ-011 SHALL have port resp_valid, output, 1: response present.
REQ-012 SHALL have port resp_ready, input, 1: core accepts the response.
REQ-013 SHALL have port resp_rdata, output, DATA_W: read data.
REQ-014 SHALL have port resp_err, output, 1: access rejected or unmapped.
REQ-015 SHALL have port mem_address, output, ADDR_W: address to the memory controller.
REQ-016 SHALL have port mem_data_in, output, DATA_W: write data to the memory controller.
REQ-017 SHALL have port mem_we, output, 1: write enable to the memory controller.
REQ-018 SHALL have port mem_data_out, input, DATA_W: read data from the memory controller.
REQ-019 SHALL have port err_count, output, 8: count of rejected accesses.

Function
REQ-020 SHALL implement the FSM IDLE -> ACCESS -> WAIT -> RESP -> IDLE.
REQ-021 SHALL assert req_ready only in IDLE; on req_valid && req_ready it SHALL latch req_we, req_addr and req_wdata, then move to ACCESS.
REQ-022 SHALL hold mem_address and mem_data_in at the latched values from ACCESS through the end of WAIT.
REQ-023 SHALL drive mem_address 0 and mem_data_in 0 in IDLE and RESP.
REQ-024 SHALL assert mem_we for exactly the one ACCESS cycle, only for a write to a writable region.
REQ-025 SHALL remain in ACCESS for 1 cycle and in WAIT for MEM_LATENCY cycles, using a down-counter.
REQ-026 SHALL capture mem_data_out into resp_rdata on the final WAIT edge.
REQ-027 SHALL assert resp_valid exactly MEM_LATENCY+1 rising edges after the accepting edge.
REQ-028 SHALL hold resp_valid, resp_rdata and resp_err stable until resp_ready=1.
REQ-029 SHALL, on resp_valid && resp_ready, return to IDLE and drop resp_valid next cycle; back-to-back accept is possible the following cycle.
REQ-030 SHALL decode regions: 0x0000-0x001F ROM (read-only); 0x0020-0x003F IO; 0x0800-0x0FFF RAM; all other addresses unmapped.
REQ-031 SHALL, for a write to ROM or an unmapped address, keep mem_we=0, still traverse ACCESS/WAIT, and give resp_err=1.
REQ-032 SHALL, for a read of an unmapped address, give resp_rdata=0 and resp_err=1.
REQ-033 SHALL return resp_rdata=0 for every write response.
REQ-034 SHALL increment err_count by 1 per response with resp_err=1, saturating at 0xFF.
REQ-035 SHALL ignore req_valid outside IDLE, with no buffering.

Reset
REQ-036 SHALL, when reset_n=0, immediately force state IDLE, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_address=0, mem_data_in=0, counter=0, err_count=0.
REQ-037 SHALL assert req_ready=1 from the first rising edge after reset_n deasserts.
REQ-038 SHALL, on reset mid-transaction, discard the in-flight access with no response, and SHALL deassert mem_we asynchronously.

Structure
REQ-039 SHALL take the region bounds (ROM/IO/RAM base and limit) and FSM state encodings from the shared scic_defs constants file.
REQ-040 SHALL place region decode in a combinational sub-module address_region_decoder (addr -> region, writable).

Verification
REQ-041 Bench SHALL check: read 0x0805 with memory returning 0xDEADBEEF, MEM_LATENCY=1 -> resp_valid on 2nd edge after accept, rdata 0xDEADBEEF, err 0.
REQ-042 Bench SHALL check: write 0x0020 data 0x0000000A -> mem_we high for exactly 1 cycle with mem_address 0x0020 and mem_data_in 0x0000000A; resp err 0, rdata 0.
REQ-043 Bench SHALL check: write 0x0010 (ROM) -> mem_we never asserted; resp_err 1; err_count 0 -> 1.
REQ-044 Bench SHALL check: read 0x4000 -> resp_rdata 0, resp_err 1.
REQ-045 Bench SHALL check: hold resp_ready=0 for 5 cycles -> response held stable, req_ready 0; after release, next request accepted one cycle later.
REQ-046 Bench SHALL check: reset_n low during WAIT -> mem_we/resp_valid 0 immediately, no response; a fresh read after reset completes normally.

Source files
------------

// File: rtl/scic_defs_pkg.sv
// Shared constants for the core bus interface: region bounds, FSM and region encodings.
// Range helper works on 32-bit zero-extended addresses so bounds stay width-independent.
package scic_defs_pkg;

    localparam logic [31:0] ROM_BASE   = 32'h0000_0000;
    localparam logic [31:0] ROM_LIMIT  = 32'h0000_001F;
    localparam logic [31:0] IO_BASE    = 32'h0000_0020;
    localparam logic [31:0] IO_LIMIT   = 32'h0000_003F;
    localparam logic [31:0] RAM_BASE   = 32'h0000_0800;
    localparam logic [31:0] RAM_LIMIT  = 32'h0000_0FFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } bus_state_e;

    typedef enum logic [1:0] {
        REGION_ROM  = 2'd0,
        REGION_IO   = 2'd1,
        REGION_RAM  = 2'd2,
        REGION_NONE = 2'd3
    } region_e;

    function automatic logic in_range(input logic [31:0] a,
                                      input logic [31:0] base,
                                      input logic [31:0] limit);
        return (a >= base) && (a <= limit);
    endfunction

endpackage

// File: rtl/address_region_decoder.sv
// Combinational address decode into ROM/IO/RAM/unmapped plus a writable flag.
// Zero latency, no flow control.
module address_region_decoder
    import scic_defs_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] addr_i,
    output region_e           region_o,
    output logic              writable_o
);

    logic [31:0] addr_ext;
    assign addr_ext = 32'(addr_i);

    always_comb begin
        region_o = REGION_NONE;
        if (in_range(addr_ext, ROM_BASE, ROM_LIMIT)) begin
            region_o = REGION_ROM;
        end else if (in_range(addr_ext, IO_BASE, IO_LIMIT)) begin
            region_o = REGION_IO;
        end else if (in_range(addr_ext, RAM_BASE, RAM_LIMIT)) begin
            region_o = REGION_RAM;
        end
    end

    assign writable_o = (region_o == REGION_IO) || (region_o == REGION_RAM);

endmodule

// File: rtl/bus_interface_unit.sv
// Single-outstanding core-to-memory bridge; response MEM_LATENCY+1 edges after accept.
// req_ready only in IDLE (no buffering); response held until resp_ready.
module bus_interface_unit
    import scic_defs_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [7:0]        err_count
);

    bus_state_e        state_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              resp_err_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [DATA_W-1:0] mem_data_in_q;
    logic              mem_we_q;
    logic [2:0]        cnt_q;
    logic [7:0]        err_count_q;
    logic              we_q;
    logic              err_q;

    region_e req_region;
    logic    req_writable;

    // Decode the incoming address so the error outcome is fixed at accept time.
    address_region_decoder #(
        .ADDR_W (ADDR_W)
    ) u_decoder (
        .addr_i     (req_addr),
        .region_o   (req_region),
        .writable_o (req_writable)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= '0;
            resp_err_q    <= 1'b0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            mem_we_q      <= 1'b0;
            cnt_q         <= '0;
            err_count_q   <= '0;
            we_q          <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        state_q       <= ST_ACCESS;
                        req_ready_q   <= 1'b0;
                        we_q          <= req_we;
                        mem_address_q <= req_addr;
                        mem_data_in_q <= req_wdata;
                        mem_we_q      <= req_we && req_writable;
                        err_q         <= req_we ? !req_writable : (req_region == REGION_NONE);
                    end
                end
                ST_ACCESS: begin
                    mem_we_q <= 1'b0;
                    cnt_q    <= 3'(MEM_LATENCY);
                    state_q  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_q == 3'd1) begin
                        state_q       <= ST_RESP;
                        cnt_q         <= '0;
                        resp_valid_q  <= 1'b1;
                        resp_rdata_q  <= (we_q || err_q) ? '0 : mem_data_out;
                        resp_err_q    <= err_q;
                        mem_address_q <= '0;
                        mem_data_in_q <= '0;
                        if (err_q && (err_count_q != 8'hFF)) begin
                            err_count_q <= err_count_q + 8'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_q      <= ST_IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_we      = mem_we_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_bus_interface_unit.sv
// Directed bench for bus_interface_unit with MEM_LATENCY=1; inputs driven at negedge
// or #1 after posedge, outputs sampled at negedge.
module tb_bus_interface_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [15:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_we;
    logic [31:0] mem_data_out;
    logic [7:0]  err_count;

    int checks = 0;
    int failures = 0;

    // Results of the most recent run_txn call.
    int          edges;
    int          we_cyc;
    int          stall;
    logic        to;
    logic [15:0] acc_addr;
    logic [15:0] we_addr;
    logic [31:0] we_data;

    always #5 clock = ~clock;

    bus_interface_unit #(
        .MEM_LATENCY (1),
        .ADDR_W      (16),
        .DATA_W      (32)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_we       (mem_we),
        .mem_data_out (mem_data_out),
        .err_count    (err_count)
    );

    // Called just after a negedge; returns at a negedge with the response visible.
    task automatic run_txn(input logic we, input logic [15:0] addr, input logic [31:0] wdata);
        to = 1'b0; stall = 0; edges = 0; we_cyc = 0; we_addr = '0; we_data = '0; acc_addr = '0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        while (!req_ready && stall < 20) begin
            @(negedge clock);
            stall++;
        end
        if (!req_ready) begin
            to = 1'b1;
            req_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1 req_valid = 1'b0;
            @(negedge clock);
            acc_addr = mem_address;
            for (int i = 0; i < 20; i++) begin
                if (mem_we) begin
                    we_cyc++;
                    we_addr = mem_address;
                    we_data = mem_data_in;
                end
                if (resp_valid) break;
                @(posedge clock);
                edges++;
                @(negedge clock);
            end
            if (!resp_valid) to = 1'b1;
        end
    endtask

    task automatic complete();
        resp_ready = 1'b1;
        @(posedge clock);
        #1 resp_ready = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0; mem_data_out = 32'hDEADBEEF;
        repeat (2) @(negedge clock);
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
        checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin failures++; $display("FAIL rst_resp got v=%b e=%b d=%h exp 0/0/0", resp_valid, resp_err, resp_rdata); end
        checks++; if (mem_we !== 1'b0 || mem_address !== 16'h0 || mem_data_in !== 32'h0) begin failures++; $display("FAIL rst_mem got we=%b a=%h d=%h exp 0/0/0", mem_we, mem_address, mem_data_in); end
        checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL rst_err_count got=%h exp=00", err_count); end
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_first_edge got=%b exp=1", req_ready); end
    endtask

    task automatic test_read_ram();
        mem_data_out = 32'hDEADBEEF;
        run_txn(1'b0, 16'h0805, 32'h0);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL rd_ram_timeout got=%b exp=0", to); end
        checks++; if (edges !== 2) begin failures++; $display("FAIL rd_ram_latency got=%0d exp=2", edges); end
        checks++; if (acc_addr !== 16'h0805) begin failures++; $display("FAIL rd_ram_mem_address got=%h exp=0805", acc_addr); end
        checks++; if (resp_rdata !== 32'hDEADBEEF || resp_err !== 1'b0) begin failures++; $display("FAIL rd_ram_resp got d=%h e=%b exp DEADBEEF/0", resp_rdata, resp_err); end
        checks++; if (we_cyc !== 0 || mem_address !== 16'h0) begin failures++; $display("FAIL rd_ram_mem_idle got we_cyc=%0d a=%h exp 0/0000", we_cyc, mem_address); end
        complete();
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL rd_ram_release got v=%b rdy=%b exp 0/1", resp_valid, req_ready); end
    endtask

    task automatic test_write_io();
        run_txn(1'b1, 16'h0020, 32'h0000000A);
        checks++; if (to !== 1'b0 || we_cyc !== 1) begin failures++; $display("FAIL wr_io_we_cycles got=%0d to=%b exp=1", we_cyc, to); end
        checks++; if (we_addr !== 16'h0020 || we_data !== 32'h0000000A) begin failures++; $display("FAIL wr_io_mem_bus got a=%h d=%h exp 0020/0000000A", we_addr, we_data); end
        checks++; if (resp_err !== 1'b0 || resp_rdata !== 32'h0) begin failures++; $display("FAIL wr_io_resp got e=%b d=%h exp 0/00000000", resp_err, resp_rdata); end
        complete();
        checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL wr_io_err_count got=%h exp=00", err_count); end
    endtask

    task automatic test_write_rom();
        run_txn(1'b1, 16'h0010, 32'h12345678);
        checks++; if (to !== 1'b0 || we_cyc !== 0) begin failures++; $display("FAIL wr_rom_we got=%0d to=%b exp=0", we_cyc, to); end
        checks++; if (edges !== 2) begin failures++; $display("FAIL wr_rom_latency got=%0d exp=2", edges); end
        checks++; if (resp_err !== 1'b1 || resp_rdata !== 32'h0) begin failures++; $display("FAIL wr_rom_resp got e=%b d=%h exp 1/00000000", resp_err, resp_rdata); end
        complete();
        checks++; if (err_count !== 8'h01) begin failures++; $display("FAIL wr_rom_err_count got=%h exp=01", err_count); end
    endtask

    task automatic test_read_unmapped();
        run_txn(1'b0, 16'h4000, 32'h0);
        checks++; if (to !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b1) begin failures++; $display("FAIL rd_unmapped_resp got d=%h e=%b to=%b exp 00000000/1/0", resp_rdata, resp_err, to); end
        complete();
        checks++; if (err_count !== 8'h02) begin failures++; $display("FAIL rd_unmapped_err_count got=%h exp=02", err_count); end
        run_txn(1'b0, 16'h001F, 32'h0);
        checks++; if (to !== 1'b0 || resp_rdata !== 32'hDEADBEEF || resp_err !== 1'b0) begin failures++; $display("FAIL rd_rom_edge_resp got d=%h e=%b exp DEADBEEF/0", resp_rdata, resp_err); end
        complete();
        run_txn(1'b1, 16'h0040, 32'h1);
        checks++; if (to !== 1'b0 || we_cyc !== 0 || resp_err !== 1'b1) begin failures++; $display("FAIL wr_0040_unmapped got we_cyc=%0d e=%b exp 0/1", we_cyc, resp_err); end
        complete();
        checks++; if (err_count !== 8'h03) begin failures++; $display("FAIL wr_0040_err_count got=%h exp=03", err_count); end
    endtask

    task automatic test_hold();
        mem_data_out = 32'h12345678;
        run_txn(1'b0, 16'h0FFF, 32'h0);
        mem_data_out = 32'hFFFFFFFF;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0800;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            @(negedge clock);
            checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h12345678 || resp_err !== 1'b0) begin failures++; $display("FAIL hold_resp_%0d got v=%b d=%h e=%b exp 1/12345678/0", i, resp_valid, resp_rdata, resp_err); end
            checks++; if (req_ready !== 1'b0 || mem_address !== 16'h0) begin failures++; $display("FAIL hold_ready_%0d got rdy=%b a=%h exp 0/0000", i, req_ready, mem_address); end
        end
        complete();
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL hold_release got v=%b rdy=%b exp 0/1", resp_valid, req_ready); end
        run_txn(1'b0, 16'h0800, 32'h0);
        checks++; if (to !== 1'b0 || stall !== 0 || edges !== 2) begin failures++; $display("FAIL b2b_accept got stall=%0d edges=%0d exp 0/2", stall, edges); end
        checks++; if (resp_rdata !== 32'hFFFFFFFF || resp_err !== 1'b0) begin failures++; $display("FAIL b2b_resp got d=%h e=%b exp FFFFFFFF/0", resp_rdata, resp_err); end
        complete();
    endtask

    task automatic test_reset_mid();
        int seen;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0900; req_wdata = 32'h55;
        @(posedge clock);
        #1 req_valid = 1'b0;
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL mid_access_we got=%b exp=1", mem_we); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0 || mem_address !== 16'h0 || req_ready !== 1'b0 || err_count !== 8'h00) begin failures++; $display("FAIL mid_access_async got we=%b a=%h rdy=%b ec=%h exp 0/0000/0/00", mem_we, mem_address, req_ready, err_count); end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0900;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0 || mem_we !== 1'b0 || mem_address !== 16'h0) begin failures++; $display("FAIL mid_wait_async got v=%b we=%b a=%h exp 0/0/0000", resp_valid, mem_we, mem_address); end
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (resp_valid) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL mid_wait_no_resp got=%0d exp=0", seen); end
        mem_data_out = 32'hCAFEF00D;
        run_txn(1'b0, 16'h0A00, 32'h0);
        checks++; if (to !== 1'b0 || edges !== 2 || resp_rdata !== 32'hCAFEF00D || resp_err !== 1'b0) begin failures++; $display("FAIL post_reset_read got edges=%0d d=%h e=%b exp 2/CAFEF00D/0", edges, resp_rdata, resp_err); end
        complete();
    endtask

    task automatic test_err_saturation();
        int tos;
        tos = 0;
        for (int i = 0; i < 256; i++) begin
            run_txn(1'b0, 16'h1000, 32'h0);
            if (to) tos++;
            complete();
            if (i == 253) begin
                checks++; if (err_count !== 8'hFE) begin failures++; $display("FAIL err_count_254 got=%h exp=FE", err_count); end
            end
        end
        checks++; if (tos !== 0) begin failures++; $display("FAIL sat_timeouts got=%0d exp=0", tos); end
        checks++; if (err_count !== 8'hFF) begin failures++; $display("FAIL err_count_sat got=%h exp=FF", err_count); end
    endtask

    initial begin
        test_reset();
        test_read_ram();
        test_write_io();
        test_write_rom();
        test_read_unmapped();
        test_hold();
        test_reset_mid();
        test_err_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
